rv32i_multiciclo: RTL and testbench
===================================

RV32I_MULTICICLO -- requirements
Module: rv32i_multiciclo

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter NREGS, default 32, register-file depth; legal values 16 (RV32E) or 32.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mem_req  output  1  memory access request, held until mem_ready.
REQ-006 mem_we  output  1  write strobe, valid only while mem_req=1.
REQ-007 mem_addr  output  32  byte address of current access.
REQ-008 mem_wdata  output  32  store data (rs2 value); equals rd2.
REQ-009 mem_rdata  input  32  read data, valid when mem_ready=1.
REQ-010 mem_ready  input  1  access completes on the edge where mem_req=1 and mem_ready=1.
REQ-011 pc  output  32  address of the instruction in progress.
REQ-012 ALUResult  output  32  registered ALU output of the last EXECUTE.
REQ-013 trap  output  1  core halted on illegal or misaligned condition.

Function
REQ-014 Unified instruction/data port; one access at a time; no combinational path from mem_ready to mem_req.
REQ-015 Supported: LUI; ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; ADD SUB SLL SLT SLTU XOR SRL SRA OR AND; LW; SW; BEQ BNE BLT BGE BLTU BGEU; JAL; JALR.
REQ-016 FSM states FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-017 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on handshake latch IR, go DECODE; else stay.
REQ-018 DECODE: latch rs1/rs2 into A/B and sign-extended immediate; unsupported opcode/funct or register index >= NREGS -> TRAP.
REQ-019 EXECUTE: latch ALUResult; LW/SW -> MEM; ALU/LUI/JAL/JALR -> WB; branch: pc <= taken ? pc+immB : pc+4, -> FETCH.
REQ-020 MEM: mem_req=1, mem_addr=ALUResult, mem_we=1 for SW with mem_wdata=B; on handshake SW: pc<=pc+4 -> FETCH; LW: latch mem_rdata -> WB.
REQ-021 WB: write rd (LW data, pc+4 for JAL/JALR, else ALUResult); pc <= jump target or pc+4; -> FETCH.
REQ-022 Writes to x0 discarded; x0 reads 0 always.
REQ-023 Latency with mem_ready tied high: branch 3, ALU/LUI/JAL/JALR/SW 4, LW 5 cycles; each wait cycle adds one.
REQ-024 Branch/jump target with bits[1:0] != 0, or LW/SW address with bits[1:0] != 0 -> TRAP, pc unchanged.
REQ-025 TRAP: trap=1, mem_req=0, no state change; left only by reset.
REQ-026 Arithmetic modulo 2^32; shifts use bits[4:0]; JALR target (rs1+imm) with bit0 cleared.

Reset
REQ-027 Reset, in any state including mid-handshake: state=FETCH, pc=RESET_PC, all registers=0, ALUResult=0, IR=0, trap=0, mem_req=0 and mem_we=0 in the reset cycle.

Configuration
REQ-028 RV32I_MC_PERF_EN defined: adds outputs cycle_count[31:0] (+1 every non-reset cycle) and instret_count[31:0] (+1 per completed instruction), both wrap, reset to 0.
REQ-029 RV32I_MC_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.

Structure
REQ-030 Package rv32i_mc_pkg: state enum, opcode constants, ALU-op encoding, funct3 branch codes.
REQ-031 One sub-module rv32i_alu (combinational, op/a/b -> result, zero, lt, ltu); register file inline.

Verification
REQ-032 Reset, mem_ready=1 -> cycle after release: pc=0, mem_req=1, mem_addr=0, trap=0.
REQ-033 00300413, 00100493, 009462b3 (ADDI x8=3, ADDI x9=1, OR x5) -> ALUResult 3, 1, 3; pc=12 after 12 cycles.
REQ-034 Then 00802023 (SW x8,0(x0)) -> MEM cycle: mem_we=1, mem_addr=0, mem_wdata=3; pc=16 next.
REQ-035 mem_ready low 3 cycles during FETCH -> mem_req and mem_addr stable; instruction takes 7 cycles.
REQ-036 BEQ x0,x0,+8 at pc=16 -> pc=24 after 3 cycles; 00000000 fetched -> trap=1, mem_req=0 until reset.
REQ-037 With RV32I_MC_PERF_EN: REQ-033 sequence -> instret_count=3, cycle_count=12.

Source files
------------

// File: rtl/rv32i_mc_pkg.sv
// Shared types and constants for the rv32i_multiciclo core: FSM states,
// RV32I opcodes, ALU operation encoding and branch funct3 codes.
package rv32i_mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEM,
      S_WB,
      S_TRAP
   } state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASS_B
   } alu_op_t;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // alt selects SUB/SRA (instruction bit 30)
   function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [31:0] imm_decode(input logic [31:0] ir);
      case (ir[6:0])
         OPC_STORE:  return {{20{ir[31]}}, ir[31:25], ir[11:7]};
         OPC_BRANCH: return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         OPC_LUI:    return {ir[31:12], 12'h000};
         OPC_JAL:    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default:    return {{20{ir[31]}}, ir[31:20]};
      endcase
   endfunction

endpackage

// File: rtl/rv32i_alu.sv
// Combinational ALU for rv32i_multiciclo: result plus compare flags used by branches.
module rv32i_alu
   import rv32i_mc_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        zero,
   output logic        lt,
   output logic        ltu
);

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      result = 32'd0;
      case (op)
         ALU_ADD:    result = a + b;
         ALU_SUB:    result = a - b;
         ALU_SLL:    result = a << b[4:0];
         ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:   result = {31'd0, a < b};
         ALU_XOR:    result = a ^ b;
         ALU_SRL:    result = a >> b[4:0];
         ALU_SRA:    result = $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:     result = a | b;
         ALU_AND:    result = a & b;
         ALU_PASS_B: result = b;
         default:    result = 32'd0;
      endcase
   end

   assign zero = (result == 32'd0);
   assign lt   = $signed(a) < $signed(b);
   assign ltu  = a < b;

endmodule

// File: rtl/rv32i_multiciclo.sv
// Multi-cycle RV32I core with a single shared memory port.
// Optional performance counters are enabled by defining RV32I_MC_PERF_EN.
module rv32i_multiciclo
   import rv32i_mc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [31:0] pc,
   output logic [31:0] ALUResult,
   output logic        trap
`ifdef RV32I_MC_PERF_EN
   ,
   output logic [31:0] cycle_count,
   output logic [31:0] instret_count
`endif
);

   localparam int         AW      = $clog2(NREGS);
   localparam logic [5:0] NREGS_L = 6'(NREGS);

   state_t      state, next_state;
   logic [31:0] ir, a_reg, b_reg, imm_reg, mdr;
   logic [31:0] regs [NREGS];

   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rd_idx, rs1_idx, rs2_idx;

   assign opcode  = ir[6:0];
   assign rd_idx  = ir[11:7];
   assign funct3  = ir[14:12];
   assign rs1_idx = ir[19:15];
   assign rs2_idx = ir[24:20];
   assign funct7  = ir[31:25];

   logic is_store, is_jump;
   assign is_store = (opcode == OPC_STORE);
   assign is_jump  = (opcode == OPC_JAL) || (opcode == OPC_JALR);

   // ---------------- decode legality ----------------
   logic legal, uses_rs1, uses_rs2, writes_rd, idx_bad, decode_ok;

   always_comb begin
      legal     = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      writes_rd = 1'b0;
      case (opcode)
         OPC_LUI: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_OPIMM: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
            else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            else                       legal = 1'b1;
         end
         OPC_OP: begin
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            writes_rd = 1'b1;
            legal     = (funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_LOAD: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            legal     = (funct3 == 3'b010);
         end
         OPC_STORE: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal    = (funct3 == 3'b010);
         end
         OPC_BRANCH: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
         end
         OPC_JAL: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
         end
         OPC_JALR: begin
            uses_rs1  = 1'b1;
            writes_rd = 1'b1;
            legal     = (funct3 == 3'b000);
         end
         default: legal = 1'b0;
      endcase
   end

   // Reduced register files (RV32E) reject any operand index beyond the array
   assign idx_bad = (uses_rs1  && ({1'b0, rs1_idx} >= NREGS_L)) ||
                    (uses_rs2  && ({1'b0, rs2_idx} >= NREGS_L)) ||
                    (writes_rd && ({1'b0, rd_idx}  >= NREGS_L));
   assign decode_ok = legal && !idx_bad;

   logic [31:0] rd1, rd2;
   assign rd1 = ((rs1_idx == 5'd0) || ({1'b0, rs1_idx} >= NREGS_L)) ? 32'd0 : regs[rs1_idx[AW-1:0]];
   assign rd2 = ((rs2_idx == 5'd0) || ({1'b0, rs2_idx} >= NREGS_L)) ? 32'd0 : regs[rs2_idx[AW-1:0]];

   // ---------------- execute datapath ----------------
   alu_op_t     alu_op;
   logic [31:0] alu_a, alu_b, alu_res, exec_result;
   logic        alu_zero, alu_lt, alu_ltu;

   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = a_reg;
      alu_b  = imm_reg;
      case (opcode)
         OPC_OP: begin
            alu_op = alu_op_from_f3(funct3, ir[30]);
            alu_b  = b_reg;
         end
         OPC_OPIMM:  alu_op = alu_op_from_f3(funct3, (funct3 == 3'b101) && ir[30]);
         OPC_LUI:    alu_op = ALU_PASS_B;
         OPC_BRANCH: begin
            alu_op = ALU_SUB;
            alu_b  = b_reg;
         end
         OPC_JAL:    alu_a = pc;
         default:    alu_op = ALU_ADD;
      endcase
   end

   rv32i_alu u_alu (
      .op     (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_res),
      .zero   (alu_zero),
      .lt     (alu_lt),
      .ltu    (alu_ltu)
   );

   assign exec_result = (opcode == OPC_JALR) ? {alu_res[31:1], 1'b0} : alu_res;

   logic        br_taken;
   logic [31:0] br_target, pc_plus4;
   assign br_target = pc + imm_reg;
   assign pc_plus4  = pc + 32'd4;

   always_comb begin
      br_taken = 1'b0;
      case (funct3)
         F3_BEQ:  br_taken = alu_zero;
         F3_BNE:  br_taken = !alu_zero;
         F3_BLT:  br_taken = alu_lt;
         F3_BGE:  br_taken = !alu_lt;
         F3_BLTU: br_taken = alu_ltu;
         F3_BGEU: br_taken = !alu_ltu;
         default: br_taken = 1'b0;
      endcase
   end

   // ---------------- FSM ----------------
   always_comb begin
      next_state = state;
      case (state)
         S_FETCH:  if (mem_ready) next_state = S_DECODE;
         S_DECODE: next_state = decode_ok ? S_EXECUTE : S_TRAP;
         S_EXECUTE: begin
            case (opcode)
               OPC_LOAD, OPC_STORE:
                  next_state = (exec_result[1:0] != 2'b00) ? S_TRAP : S_MEM;
               OPC_BRANCH:
                  next_state = (br_taken && (br_target[1:0] != 2'b00)) ? S_TRAP : S_FETCH;
               OPC_JAL, OPC_JALR:
                  next_state = (exec_result[1:0] != 2'b00) ? S_TRAP : S_WB;
               default: next_state = S_WB;
            endcase
         end
         S_MEM:    if (mem_ready) next_state = is_store ? S_FETCH : S_WB;
         S_WB:     next_state = S_FETCH;
         S_TRAP:   next_state = S_TRAP;
         default:  next_state = S_FETCH;
      endcase
   end

   // NOTE: clocked state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Outputs depend on state only (plus reset), never on mem_ready
   assign mem_req   = !reset && ((state == S_FETCH) || (state == S_MEM));
   assign mem_we    = !reset && (state == S_MEM) && is_store;
   assign mem_addr  = (state == S_MEM) ? ALUResult : pc;
   assign mem_wdata = b_reg;
   assign trap      = (state == S_TRAP);

   logic [31:0] wb_data;
   always_comb begin
      case (opcode)
         OPC_LOAD:          wb_data = mdr;
         OPC_JAL, OPC_JALR: wb_data = pc_plus4;
         default:           wb_data = ALUResult;
      endcase
   end

   // NOTE: the register file is cleared on reset, so it is built from flops rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc        <= RESET_PC;
         ir        <= 32'd0;
         a_reg     <= 32'd0;
         b_reg     <= 32'd0;
         imm_reg   <= 32'd0;
         mdr       <= 32'd0;
         ALUResult <= 32'd0;
         for (int i = 0; i < NREGS; i++) regs[i] <= 32'd0;
      end else begin
         case (state)
            S_FETCH: if (mem_ready) ir <= mem_rdata;
            S_DECODE: begin
               a_reg   <= rd1;
               b_reg   <= rd2;
               imm_reg <= imm_decode(ir);
            end
            S_EXECUTE: begin
               ALUResult <= exec_result;
               if ((opcode == OPC_BRANCH) && (next_state == S_FETCH))
                  pc <= br_taken ? br_target : pc_plus4;
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (is_store) pc  <= pc_plus4;
                  else          mdr <= mem_rdata;
               end
            end
            S_WB: begin
               if (rd_idx != 5'd0) regs[rd_idx[AW-1:0]] <= wb_data;
               pc <= is_jump ? ALUResult : pc_plus4;
            end
            default: ;
         endcase
      end
   end

`ifdef RV32I_MC_PERF_EN
   logic retire;
   assign retire = ((state == S_EXECUTE) && (opcode == OPC_BRANCH) && (next_state == S_FETCH)) ||
                   ((state == S_MEM) && mem_ready && is_store) ||
                   (state == S_WB);

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count   <= 32'd0;
         instret_count <= 32'd0;
      end else begin
         cycle_count <= cycle_count + 32'd1;
         if (retire) instret_count <= instret_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rv32i_multiciclo.sv
// Self-checking bench for rv32i_multiciclo: directed bring-up sequence, then
// random programs compared against an instruction-level reference model.
module tb_rv32i_multiciclo;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req, mem_we, mem_ready, trap;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, alu_result;
`ifdef RV32I_MC_PERF_EN
   logic [31:0] cycle_count, instret_count;
`endif

   rv32i_multiciclo dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .ALUResult (alu_result),
      .trap      (trap)
`ifdef RV32I_MC_PERF_EN
      ,
      .cycle_count   (cycle_count),
      .instret_count (instret_count)
`endif
   );

   always #5 clk = ~clk;

   // 1 KiB memory: code from 0x000, store area 0x200, load area 0x300
   logic [31:0] mem  [256];
   logic [31:0] dmem [256];
   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk)
      if (mem_req && mem_we && mem_ready) mem[mem_addr[9:2]] <= mem_wdata;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- program representation ----------------
   typedef enum int {
      K_ADDI, K_SLTI, K_SLTIU, K_XORI, K_ORI, K_ANDI, K_SLLI, K_SRLI, K_SRAI,
      K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
      K_LUI, K_LW, K_SW, K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU,
      K_JAL, K_JALR, K_HALT
   } kind_e;

   typedef struct {
      kind_e       kind;
      int          rd;
      int          rs1;
      int          rs2;
      logic [31:0] imm;
   } instr_t;

   instr_t prog [64];

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {im, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_b(input logic [31:0] im, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3);
      return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] encode(input instr_t in);
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] im;
      rd  = in.rd[4:0];
      rs1 = in.rs1[4:0];
      rs2 = in.rs2[4:0];
      im  = in.imm;
      case (in.kind)
         K_ADDI:  return enc_i(im[11:0], rs1, 3'b000, rd, 7'h13);
         K_SLTI:  return enc_i(im[11:0], rs1, 3'b010, rd, 7'h13);
         K_SLTIU: return enc_i(im[11:0], rs1, 3'b011, rd, 7'h13);
         K_XORI:  return enc_i(im[11:0], rs1, 3'b100, rd, 7'h13);
         K_ORI:   return enc_i(im[11:0], rs1, 3'b110, rd, 7'h13);
         K_ANDI:  return enc_i(im[11:0], rs1, 3'b111, rd, 7'h13);
         K_SLLI:  return enc_i({7'h00, im[4:0]}, rs1, 3'b001, rd, 7'h13);
         K_SRLI:  return enc_i({7'h00, im[4:0]}, rs1, 3'b101, rd, 7'h13);
         K_SRAI:  return enc_i({7'h20, im[4:0]}, rs1, 3'b101, rd, 7'h13);
         K_ADD:   return enc_r(7'h00, rs2, rs1, 3'b000, rd);
         K_SUB:   return enc_r(7'h20, rs2, rs1, 3'b000, rd);
         K_SLL:   return enc_r(7'h00, rs2, rs1, 3'b001, rd);
         K_SLT:   return enc_r(7'h00, rs2, rs1, 3'b010, rd);
         K_SLTU:  return enc_r(7'h00, rs2, rs1, 3'b011, rd);
         K_XOR:   return enc_r(7'h00, rs2, rs1, 3'b100, rd);
         K_SRL:   return enc_r(7'h00, rs2, rs1, 3'b101, rd);
         K_SRA:   return enc_r(7'h20, rs2, rs1, 3'b101, rd);
         K_OR:    return enc_r(7'h00, rs2, rs1, 3'b110, rd);
         K_AND:   return enc_r(7'h00, rs2, rs1, 3'b111, rd);
         K_LUI:   return {im[31:12], rd, 7'b0110111};
         K_LW:    return enc_i(im[11:0], rs1, 3'b010, rd, 7'h03);
         K_SW:    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
         K_BEQ:   return enc_b(im, rs2, rs1, 3'b000);
         K_BNE:   return enc_b(im, rs2, rs1, 3'b001);
         K_BLT:   return enc_b(im, rs2, rs1, 3'b100);
         K_BGE:   return enc_b(im, rs2, rs1, 3'b101);
         K_BLTU:  return enc_b(im, rs2, rs1, 3'b110);
         K_BGEU:  return enc_b(im, rs2, rs1, 3'b111);
         K_JAL:   return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
         K_JALR:  return enc_i(im[11:0], rs1, 3'b000, rd, 7'h67);
         default: return 32'h0000_0000;
      endcase
   endfunction

   // 40 random instructions, then stores of x0..x15 to 0x200.., then an illegal word
   task automatic gen_program();
      for (int k = 0; k < 256; k++) mem[k] = 32'd0;
      for (int k = 192; k < 200; k++) mem[k] = $urandom;
      for (int i = 0; i < 40; i++) begin
         int c;
         c = int'($urandom_range(0, 9));
         prog[i].rd  = int'($urandom_range(0, 15));
         prog[i].rs1 = int'($urandom_range(0, 15));
         prog[i].rs2 = int'($urandom_range(0, 15));
         prog[i].imm = 32'($urandom_range(0, 4095)) - 32'd2048;
         if (c <= 2) begin
            prog[i].kind = kind_e'(int'(K_ADDI) + int'($urandom_range(0, 8)));
            if (prog[i].kind inside {K_SLLI, K_SRLI, K_SRAI}) prog[i].imm = 32'($urandom_range(0, 31));
         end else if (c <= 5) begin
            prog[i].kind = kind_e'(int'(K_ADD) + int'($urandom_range(0, 9)));
         end else if (c == 6) begin
            prog[i].kind = K_LUI;
            prog[i].imm  = $urandom & 32'hFFFF_F000;
         end else if (c == 7) begin
            prog[i].kind = K_LW;
            prog[i].rs1  = 0;
            prog[i].imm  = 32'h300 + 32'(4 * $urandom_range(0, 7));
         end else if (c == 8) begin
            prog[i].kind = kind_e'(int'(K_BEQ) + int'($urandom_range(0, 5)));
            prog[i].imm  = 32'd8;
         end else if ($urandom_range(0, 1) == 0) begin
            prog[i].kind = K_JAL;
            prog[i].imm  = 32'd8;
         end else begin
            prog[i].kind = K_JALR;
            prog[i].rs1  = 0;
            prog[i].imm  = 32'(4 * i + 8);
         end
      end
      for (int i = 40; i < 56; i++) begin
         prog[i].kind = K_SW;
         prog[i].rd   = 0;
         prog[i].rs1  = 0;
         prog[i].rs2  = i - 40;
         prog[i].imm  = 32'h200 + 32'(4 * (i - 40));
      end
      prog[56].kind = K_HALT;
      prog[56].rd   = 0;
      prog[56].rs1  = 0;
      prog[56].rs2  = 0;
      prog[56].imm  = 32'd0;
      for (int i = 0; i < 57; i++) mem[i] = encode(prog[i]);
      for (int k = 0; k < 256; k++) dmem[k] = mem[k];
   endtask

   // Instruction-level reference: architectural effect and cycle cost per instruction
   task automatic run_model(output int exp_cycles, output int exp_instret, output logic [31:0] exp_pc);
      logic [31:0] r [16];
      logic [31:0] p, a, b, res, np, ea;
      logic        wr, tk;
      instr_t      in;
      p = 32'd0;
      exp_cycles  = 0;
      exp_instret = 0;
      for (int i = 0; i < 16; i++) r[i] = 32'd0;
      for (int s = 0; s < 500; s++) begin
         in = prog[p[7:2]];
         if (in.kind == K_HALT) break;
         a   = r[in.rs1];
         b   = r[in.rs2];
         res = 32'd0;
         wr  = 1'b1;
         tk  = 1'b0;
         np  = p + 32'd4;
         ea  = a + in.imm;
         case (in.kind)
            K_ADDI:  res = a + in.imm;
            K_SLTI:  res = ($signed(a) < $signed(in.imm)) ? 32'd1 : 32'd0;
            K_SLTIU: res = (a < in.imm) ? 32'd1 : 32'd0;
            K_XORI:  res = a ^ in.imm;
            K_ORI:   res = a | in.imm;
            K_ANDI:  res = a & in.imm;
            K_SLLI:  res = a << in.imm[4:0];
            K_SRLI:  res = a >> in.imm[4:0];
            K_SRAI:  res = $unsigned($signed(a) >>> in.imm[4:0]);
            K_ADD:   res = a + b;
            K_SUB:   res = a - b;
            K_SLL:   res = a << b[4:0];
            K_SLT:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU:  res = (a < b) ? 32'd1 : 32'd0;
            K_XOR:   res = a ^ b;
            K_SRL:   res = a >> b[4:0];
            K_SRA:   res = $unsigned($signed(a) >>> b[4:0]);
            K_OR:    res = a | b;
            K_AND:   res = a & b;
            K_LUI:   res = in.imm;
            K_LW:    res = dmem[ea[9:2]];
            K_SW: begin
               dmem[ea[9:2]] = b;
               wr = 1'b0;
            end
            K_JAL: begin
               res = p + 32'd4;
               np  = p + in.imm;
            end
            K_JALR: begin
               res = p + 32'd4;
               np  = ea & ~32'd1;
            end
            default: begin
               wr = 1'b0;
               case (in.kind)
                  K_BEQ:   tk = (a == b);
                  K_BNE:   tk = (a != b);
                  K_BLT:   tk = ($signed(a) < $signed(b));
                  K_BGE:   tk = ($signed(a) >= $signed(b));
                  K_BLTU:  tk = (a < b);
                  default: tk = (a >= b);
               endcase
               if (tk) np = p + in.imm;
            end
         endcase
         if (wr && (in.rd != 0)) r[in.rd] = res;
         if (in.kind inside {K_BEQ, K_BNE, K_BLT, K_BGE, K_BLTU, K_BGEU}) exp_cycles += 3;
         else if (in.kind == K_LW)                                        exp_cycles += 5;
         else                                                             exp_cycles += 4;
         exp_instret++;
         p = np;
      end
      exp_pc = p;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          exp_cycles, exp_instret, n;
      logic [31:0] exp_pc;

      // ---------------- directed bring-up ----------------
      for (int k = 0; k < 256; k++) mem[k] = 32'd0;
      mem[0] = 32'h0030_0413;   // addi x8, x0, 3
      mem[1] = 32'h0010_0493;   // addi x9, x0, 1
      mem[2] = 32'h0094_62b3;   // or   x5, x8, x9
      mem[3] = 32'h0080_2023;   // sw   x8, 0(x0)
      mem[4] = 32'h0000_0463;   // beq  x0, x0, +8
      mem[5] = 32'h0050_0513;   // addi x10, x0, 5 (skipped)
      mem[6] = 32'h0000_0000;   // illegal

      reset     = 1'b1;
      mem_ready = 1'b1;
      tick();
      tick();
      check("rst_mem_req", mem_req, 32'd0);
      check("rst_mem_we", mem_we, 32'd0);
      check("rst_pc", pc, 32'd0);
      check("rst_alu", alu_result, 32'd0);
      check("rst_trap", trap, 32'd0);

      reset = 1'b0;
      #1;
      check("rel_pc", pc, 32'd0);
      check("rel_mem_req", mem_req, 32'd1);
      check("rel_mem_addr", mem_addr, 32'd0);
      check("rel_trap", trap, 32'd0);

      repeat (4) tick();
      check("addi_x8_alu", alu_result, 32'd3);
      repeat (4) tick();
      check("addi_x9_alu", alu_result, 32'd1);
      repeat (4) tick();
      check("or_x5_alu", alu_result, 32'd3);
      check("pc_after_12", pc, 32'd12);
`ifdef RV32I_MC_PERF_EN
      check("perf_instret", instret_count, 32'd3);
      check("perf_cycles", cycle_count, 32'd12);
`endif

      // SW with three fetch wait cycles
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_mem_req", mem_req, 32'd1);
         check("stall_mem_addr", mem_addr, 32'd12);
      end
      mem_ready = 1'b1;
      repeat (3) tick();
      check("sw_mem_we", mem_we, 32'd1);
      check("sw_mem_addr", mem_addr, 32'd0);
      check("sw_mem_wdata", mem_wdata, 32'd3);
      check("sw_pc_hold", pc, 32'd12);
      tick();
      check("sw_pc_next", pc, 32'd16);
      check("sw_mem_word", mem[0], 32'd3);

      repeat (3) tick();
      check("beq_pc", pc, 32'd24);
      repeat (2) tick();
      check("trap_set", trap, 32'd1);
      check("trap_mem_req", mem_req, 32'd0);
      repeat (3) tick();
      check("trap_hold", trap, 32'd1);
      check("trap_pc", pc, 32'd24);

      // ---------------- random programs vs reference model ----------------
      for (int it = 0; it < 3; it++) begin
         reset = 1'b1;
         tick();
         gen_program();
         run_model(exp_cycles, exp_instret, exp_pc);
         tick();
         check("rnd_rst_trap", trap, 32'd0);
         reset = 1'b0;
         n = 0;
         while (!trap && n < 3000) begin
            tick();
            n++;
         end
         check("rnd_trap_reached", trap, 32'd1);
         check("rnd_cycles", 32'(n), 32'(exp_cycles + 2));
         check("rnd_trap_pc", pc, exp_pc);
`ifdef RV32I_MC_PERF_EN
         check("rnd_instret", instret_count, 32'(exp_instret));
         check("rnd_cycle_count", cycle_count, 32'(exp_cycles + 2));
`endif
         for (int k = 0; k < 16; k++) check($sformatf("rnd_x%0d", k), mem[128 + k], dmem[128 + k]);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
